// File: rtl/jt12_pg_acc.sv
// jt12_pg_acc
// -----------------------------------------------------------------------------
// Per-operator phase accumulator for the JT12 phase generator. It sits right
// after the pure phase-increment stage. For the operator slot being processed
// this cycle it applies detune and the frequency multiplier to the 17-bit pure
// increment, then adds the result to that slot's 20-bit phase. The phases of all
// slots circulate in a chain of NUM_SLOTS registers.
//
// Pipeline (every stage advances only on clk edges with clk_en = 1):
//   Stage I  : premul  = phinc_pure + sext(detune)   (mod 2^17)
//              phinc_q = mul == 0 ? premul >> 1 : (premul * mul)[19:0]
//              keyon_q = keyon_now
//   Stage II : chain[0] = keyon_q ? 0 : chain[NUM_SLOTS-1] + phinc_q  (mod 2^PW)
//              Every other chain entry takes the value of the entry before it.
//
// The chain tail holds the value written NUM_SLOTS enables earlier. That value is
// the previous phase of the slot now leaving stage I. The block has no slot
// counter; the upstream sequencer sets the slot alignment.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset; clears every register
//   clk_en     : slot-advance enable
//   phinc_pure : pure phase increment for the current slot (17 bits)
//   detune     : signed detune offset, two's complement -32..+31 (6 bits)
//   mul        : frequency multiplier, 0 means x1/2 (4 bits)
//   keyon_now  : phase reset request for the current slot
//   phase_op   : top 10 phase bits of the slot just updated
// -----------------------------------------------------------------------------
module jt12_pg_acc #(
  parameter int unsigned NUM_SLOTS = 24,
  parameter int unsigned PW        = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [16:0] phinc_pure,
  input  logic [5:0]  detune,
  input  logic [3:0]  mul,
  input  logic        keyon_now,
  output logic [9:0]  phase_op
);

  // ---------------------------------------------------------------------------
  // Stage I: detune and multiplier
  // ---------------------------------------------------------------------------
  logic [16:0]   premul;
  logic [20:0]   product;
  logic [PW-1:0] phinc_d, phinc_q;
  logic          keyon_d, keyon_q;

  always_comb begin
    // Negative detune on a small increment wraps modulo 2^17.
    premul  = phinc_pure + {{11{detune[5]}}, detune};
    product = {4'b0, premul} * {17'b0, mul};
    phinc_d = phinc_q;
    keyon_d = keyon_q;
    if (clk_en) begin
      keyon_d = keyon_now;
      if (mul == 4'd0) begin
        phinc_d = PW'(premul[16:1]);
      end else begin
        // Bit 20 of the product is dropped.
        phinc_d = PW'(product[19:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phinc_q <= '0;
      keyon_q <= 1'b0;
    end else begin
      phinc_q <= phinc_d;
      keyon_q <= keyon_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage II: accumulate into the circulating chain
  // ---------------------------------------------------------------------------
  logic [PW-1:0] chain_d [NUM_SLOTS];
  logic [PW-1:0] chain_q [NUM_SLOTS];
  logic [PW-1:0] phase_head;
  logic [PW-1:0] phase_ii;

  always_comb begin
    phase_head = chain_q[NUM_SLOTS-1];
    // Key-on wins over any increment; the overflow wraps silently.
    phase_ii   = keyon_q ? '0 : phase_head + phinc_q;
    chain_d    = chain_q;
    if (clk_en) begin
      chain_d[0] = phase_ii;
      for (int unsigned i = 1; i < NUM_SLOTS; i++) begin
        chain_d[i] = chain_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  // chain_q[0] is the stage II register, so this output is registered too.
  assign phase_op = chain_q[0][PW-1 -: 10];

endmodule

// File: tb/tb_jt12_pg_acc.sv
// Directed testbench for jt12_pg_acc. Slot 0 receives the programmed increment
// and all other slots receive zero. Phase_op values are worked out by hand from
// the phase arithmetic.
module tb_jt12_pg_acc;

  localparam int unsigned NumSlots = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic [16:0] phinc_pure;
  logic [5:0]  detune;
  logic [3:0]  mul;
  logic        keyon_now;
  logic [9:0]  phase_op;

  jt12_pg_acc #(
    .NUM_SLOTS (NumSlots),
    .PW        (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .phinc_pure (phinc_pure),
    .detune     (detune),
    .mul        (mul),
    .keyon_now  (keyon_now),
    .phase_op   (phase_op)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          slot   = 0;
  int          others_bad;
  logic [9:0]  op0;
  logic [16:0] t_phinc;
  logic [5:0]  t_det;
  logic [3:0]  t_mul;
  logic        t_key;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_slot0(input logic [16:0] p, input logic [5:0] d, input logic [3:0] m,
                           input logic k);
    t_phinc = p;
    t_det   = d;
    t_mul   = m;
    t_key   = k;
  endtask

  // One enable edge. The output after an edge belongs to the slot driven on the
  // previous edge.
  task automatic step();
    int prev;
    @(negedge clk);
    if (slot == 0) begin
      phinc_pure = t_phinc;
      detune     = t_det;
      mul        = t_mul;
      keyon_now  = t_key;
    end else begin
      phinc_pure = '0;
      detune     = '0;
      mul        = '0;
      keyon_now  = 1'b0;
    end
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    prev = (slot == 0) ? NumSlots - 1 : slot - 1;
    if (prev == 0) op0 = phase_op;
    else if (phase_op !== 10'd0) others_bad++;
    slot = (slot + 1) % NumSlots;
  endtask

  task automatic rotate(input int n);
    repeat (n * NumSlots) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    clk_en     = 1'b0;
    phinc_pure = '0;
    detune     = '0;
    mul        = '0;
    keyon_now  = 1'b0;
    others_bad = 0;
    op0        = '0;
    set_slot0(17'h0, 6'h0, 4'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_phase_op", 20'(phase_op), 20'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Accumulate 0x100 per visit.
    set_slot0(17'h100, 6'h0, 4'd1, 1'b0);
    rotate(4);
    chk("acc_4rot", 20'(op0), 20'h1);
    rotate(4);
    chk("acc_8rot", 20'(op0), 20'h2);
    chk("acc_others_zero", 20'(others_bad), 20'h0);

    // Key-on together with a large increment: the phase goes to 0, then one increment.
    set_slot0(17'h200, 6'h0, 4'd15, 1'b1);
    rotate(1);
    chk("keyon_zero", 20'(op0), 20'h0);
    set_slot0(17'h200, 6'h0, 4'd15, 1'b0);
    rotate(1);
    chk("mul15_one_visit", 20'(op0), 20'h7);

    // mul = 0 halves the increment: 0x100 per visit.
    set_slot0(17'h0, 6'h0, 4'd1, 1'b1);
    rotate(1);
    chk("clear_before_mul0", 20'(op0), 20'h0);
    set_slot0(17'h200, 6'h0, 4'd0, 1'b0);
    rotate(3);
    chk("mul0_3visits", 20'(op0), 20'h0);
    rotate(1);
    chk("mul0_4visits", 20'(op0), 20'h1);

    // Detune -8 on 5 wraps to 0x1FFFD.
    set_slot0(17'h0, 6'h0, 4'd1, 1'b1);
    rotate(1);
    set_slot0(17'h00005, 6'h38, 4'd1, 1'b0);
    rotate(1);
    chk("detune_wrap", 20'(op0), 20'h07F);

    // 0x1FFFF * 15 truncates to 0xDFFF1; two visits wrap to 0xBFFE2.
    set_slot0(17'h0, 6'h0, 4'd1, 1'b1);
    rotate(1);
    set_slot0(17'h1FFFF, 6'h0, 4'd15, 1'b0);
    rotate(1);
    chk("ovf_1visit", 20'(op0), 20'h37F);
    rotate(1);
    chk("ovf_2visits", 20'(op0), 20'h2FF);

    // Gating: stop mid-rotation and wiggle the inputs while clk_en is low.
    set_slot0(17'h0, 6'h0, 4'd1, 1'b0);
    step();
    step();
    chk("gate_start", 20'(phase_op), 20'h2FF);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      phinc_pure = 17'($urandom);
      detune     = 6'($urandom);
      mul        = 4'($urandom);
      keyon_now  = 1'b1;
      clk_en     = 1'b0;
      @(posedge clk);
      #1;
      chk("gate_hold", 20'(phase_op), 20'h2FF);
    end
    while (slot != 0) step();
    step();
    step();
    chk("gate_resume", 20'(op0), 20'h2FF);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_now", 20'(phase_op), 20'h0);
    #1;
    rst_n = 1'b1;
    while (slot != 0) step();
    others_bad = 0;
    rotate(1);
    chk("post_reset_slot0", 20'(op0), 20'h0);
    chk("post_reset_others", 20'(others_bad), 20'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
